// File: rtl/noc_pkg.sv
// Shared router definitions: output port indices, input-unit FSM states and XY routing.
package noc_pkg;

   localparam logic [2:0] PORT_LOCAL = 3'd0;
   localparam logic [2:0] PORT_NORTH = 3'd1;
   localparam logic [2:0] PORT_EAST  = 3'd2;
   localparam logic [2:0] PORT_SOUTH = 3'd3;
   localparam logic [2:0] PORT_WEST  = 3'd4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      SEND = 2'd2
   } state_e;

   // Dimension-ordered routing: resolve X fully before Y.
   function automatic logic [2:0] xy_route(input int unsigned dest_x, input int unsigned dest_y,
                                           input int unsigned x_id, input int unsigned y_id);
      if (dest_x > x_id) return PORT_EAST;
      if (dest_x < x_id) return PORT_WEST;
      if (dest_y > y_id) return PORT_NORTH;
      if (dest_y < y_id) return PORT_SOUTH;
      return PORT_LOCAL;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with wrap-bit pointers and a combinational head for same-cycle routing.
module sync_fifo #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head,
   output logic              full,
   output logic              empty
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [AW:0]       wr_ptr_reg;
   logic [AW:0]       rd_ptr_reg;
   logic [DATA_W-1:0] mem [FIFO_DEPTH];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      end
   end

   // Storage needs no reset: the pointers alone define what is valid.
   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
   end

   assign head  = mem[rd_ptr_reg[AW-1:0]];
   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

endmodule

// File: rtl/xy_input_requester.sv
// Router input unit: buffers flits, XY-routes the head and requests the output arbiter until granted.
// Optional REQ_STALL_CNT_EN adds stall_o, flagging requests left ungranted for STALL_LIMIT cycles.
module xy_input_requester
   import noc_pkg::*;
#(
   parameter int OUT_N       = 5,
   parameter int DATA_W      = 8,
   parameter int COORD_W     = 2,
   parameter int X_ID        = 1,
   parameter int Y_ID        = 1,
   parameter int FIFO_DEPTH  = 4,
   parameter int STALL_LIMIT = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [DATA_W-1:0] data_i,
   input  logic              valid_i,
   output logic              ready_o,
   output logic [OUT_N-1:0]  req_o,
   input  logic [OUT_N-1:0]  grant_i,
   output logic [DATA_W-1:0] data_o,
   output logic              valid_o
`ifdef REQ_STALL_CNT_EN
   ,
   output logic              stall_o
`endif
);

   state_e            state_reg, state_next;
   logic              push, pop, full, empty, grant_hit;
   logic [DATA_W-1:0] head;
   logic [2:0]        route;
   logic [DATA_W-1:0] data_reg;
   logic              valid_reg;

   sync_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .push      (push),
      .push_data (data_i),
      .pop       (pop),
      .head      (head),
      .full      (full),
      .empty     (empty)
   );

   assign ready_o = !full;
   assign push    = valid_i & ready_o;
   assign route   = xy_route(32'(head[COORD_W-1:0]), 32'(head[2*COORD_W-1:COORD_W]),
                             32'(X_ID), 32'(Y_ID));

   genvar gi;
   generate
      for (gi = 0; gi < OUT_N; gi++) begin : g_req
         assign req_o[gi] = (state_reg == REQ) && (route == 3'(gi));
      end
   endgenerate

   // Only the grant bit matching our own request can be set in the AND.
   assign grant_hit = |(req_o & grant_i);
   assign pop       = grant_hit;

   // A push is counted as non-empty so the request rises the cycle after the flit lands.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (push || !empty) state_next = REQ;
         REQ:     if (grant_hit) state_next = SEND;
         SEND:    state_next = (push || !empty) ? REQ : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_reg <= IDLE;
         data_reg  <= '0;
         valid_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         valid_reg <= grant_hit;
         if (grant_hit) data_reg <= head;
      end
   end

   assign data_o  = data_reg;
   assign valid_o = valid_reg;

`ifdef REQ_STALL_CNT_EN
   localparam int CNT_W = $clog2(STALL_LIMIT) + 1;
   logic [CNT_W-1:0] stall_cnt_reg;

   always_ff @(posedge clk_i) begin
      if (!rst_ni || grant_hit) begin
         stall_cnt_reg <= '0;
      end else if (state_reg == REQ && stall_cnt_reg != '1) begin
         stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
   end

   assign stall_o = (stall_cnt_reg >= CNT_W'(STALL_LIMIT));
`else
   localparam int STALL_LIMIT_UNUSED = STALL_LIMIT;
`endif

endmodule
